demux4_dispatch: RTL and testbench
==================================

# demux4_dispatch

Sequencing controller for the 1-to-4 demultiplexer path. It accepts data words on a single valid/ready input stream and delivers each to exactly one of four output channels, selected either by an explicit destination field or by an internal round-robin pointer. A one-word holding register tolerates per-channel backpressure and sustains one word per cycle when the target channel is ready. A stall timeout lets round-robin traffic skip a blocked channel.

## Interface

Parameters:
- DW, 8: data word width.
- TIMEOUT, 16: stall cycles before the timeout action; 0 disables it. Legal range is 0..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DW  input word.
- in_dest  in  2  target channel when mode=0.
- mode  in  1  0 = addressed (use in_dest); 1 = round-robin (use rr pointer). Sampled at accept.
- out_valid  out  4  one-hot (or zero) channel valid; bit n belongs to channel n.
- out_ready  in  4  per-channel ready.
- out_data  out  DW  held word, shared by all channels.
- sel  out  2  channel currently targeted by the held word.
- busy  out  1  a word is held (state HOLD).
- timeout  out  1  one-cycle pulse on stall-timer expiry.

## Operation

- State machine with two states:
  - IDLE: no word held.
  - HOLD: word in data_q, target in sel_q, accept mode in mode_q.
- Accept event: in_valid & in_ready.
- Delivery event: HOLD & out_ready[sel_q].
- in_ready = IDLE | delivery event. This is a combinational path from out_ready.
- On accept:
  - data_q <= in_data.
  - sel_q <= (mode ? rr_ptr : in_dest).
  - mode_q <= mode.
  - wait_cnt <= 0.
  - State goes to HOLD.
- rr_ptr increments modulo 4 (3 wraps to 0) on every accept made with mode=1. It does not change on mode=0 accepts or on delivery.
- On delivery with no accept in the same cycle: state goes to IDLE.
- On delivery with an accept in the same cycle: state stays HOLD and the new word is loaded.
- Outputs:
  - out_valid = HOLD ? (1 << sel_q) : 4'b0000. It never has more than one bit set.
  - out_data = data_q. Its value is don't-care to the consumer when out_valid=0.
  - sel = sel_q.
  - busy = HOLD.
- Stall timer (active only when TIMEOUT != 0):
  - In HOLD without delivery, wait_cnt increments each cycle.
  - When wait_cnt == TIMEOUT-1 and there is no delivery: timeout pulses high for one cycle and wait_cnt <= 0.
    - mode_q=1: sel_q <= sel_q+1 (mod 4). The word is retargeted; rr_ptr is unaffected.
    - mode_q=0: sel_q is unchanged. The word keeps waiting and timeout repeats every TIMEOUT cycles.
  - Delivery takes priority over expiry in the same cycle: no pulse, no retarget.
- The held word is never dropped or duplicated. Exactly one delivery occurs per accept.

## Timing

- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, data_q=0, sel_q=0, mode_q=0, rr_ptr=0, wait_cnt=0.
  - Outputs: out_valid=0000, out_data=0, sel=0, busy=0, timeout=0, in_ready=1.
- Latency: a word accepted at edge k drives out_valid from after edge k. It is delivered at the first edge where out_ready[sel] is high.
- Throughput: 1 word/cycle when the targeted out_ready is held high.
- Under backpressure, out_data and out_valid are stable until delivery or retarget.
- Retarget (mode_q=1): out_valid moves to the next channel in the cycle after the timeout pulse.
- Reset during HOLD: the held word is discarded. All state returns to its reset value immediately, without waiting for a clock edge.
- Changes to mode or in_dest while not accepting have no effect.

## Test plan

- Reset: assert rst_n=0 mid-HOLD -> immediately out_valid=0000, busy=0, in_ready=1, sel=0. After release, the first mode=1 word goes to channel 0.
- Addressed routing: mode=0, in_dest=2, in_data=0xA5, out_ready=1111 -> next cycle out_valid=0100, out_data=0xA5. Delivered; busy drops if no new input.
- Round-robin streaming: mode=1, six back-to-back words 0x10..0x15, out_ready=1111 -> out_valid sequence 0001,0010,0100,1000,0001,0010. in_ready stays 1, no bubbles.
- Backpressure: mode=0, dest=1, out_ready=1101 for 5 cycles, then 1111 -> out_valid=0010 and out_data stable for 5 cycles, in_ready=0. Delivery on cycle 6.
- Round-robin timeout (TIMEOUT=4): word to channel 3, out_ready[3]=0 -> timeout pulse after 4 stall cycles, then out_valid=0001. The word is delivered to channel 0.
- Addressed timeout (TIMEOUT=4): dest=0, out_ready[0]=0 for 10 cycles -> timeout pulses at stall cycles 4 and 8, out_valid stays 0001. A delivery on the 4th stall cycle yields no pulse.

Source files
------------

// File: rtl/demux4_dispatch.sv
// demux4_dispatch: routes words from one valid/ready stream to one of four
// channels, chosen by an explicit destination or a round-robin pointer.
// A single holding register absorbs per-channel backpressure, and a stall
// timer lets round-robin words move on from a channel that stays blocked.
module demux4_dispatch #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_dest,
  input  logic          mode,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The timer is compiled out when TIMEOUT is zero; WAIT_LAST is the count
  // value on which the stall timer expires.
  localparam bit         TIMER_ON  = (TIMEOUT != 0);
  localparam logic [7:0] WAIT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      sel_q, sel_d;
  logic            mode_q, mode_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;

  logic            holding;
  logic            deliver;
  logic            accept;
  logic            expire;

  // Handshake and timer events; in_ready is combinational from out_ready so
  // a word can leave and another arrive in the same cycle.
  always_comb begin
    holding  = (state_q == HOLD);
    deliver  = holding && out_ready[sel_q];
    in_ready = !holding || deliver;
    accept   = in_valid && in_ready;
    expire   = TIMER_ON && holding && !deliver && (wait_cnt_q == WAIT_LAST);
  end

  // Next-state logic: an accept reloads the holder (even while delivering),
  // delivery alone empties it, and expiry restarts the timer and retargets
  // round-robin words to the next channel.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;

    if (accept) begin
      state_d    = HOLD;
      data_d     = in_data;
      sel_d      = mode ? rr_ptr_q : in_dest;
      mode_d     = mode;
      wait_cnt_d = 8'd0;
      if (mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end else if (deliver) begin
      state_d = IDLE;
    end else if (expire) begin
      wait_cnt_d = 8'd0;
      if (mode_q) begin
        sel_d = sel_q + 2'd1;
      end
    end else if (holding && TIMER_ON) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // State register; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      sel_q      <= 2'd0;
      mode_q     <= 1'b0;
      rr_ptr_q   <= 2'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output decode: one-hot valid for the targeted channel while holding.
  always_comb begin
    out_valid = holding ? (4'b0001 << sel_q) : 4'b0000;
    out_data  = data_q;
    sel       = sel_q;
    busy      = holding;
    timeout   = expire;
  end

endmodule

// File: tb/tb_demux4_dispatch.sv
// tb_demux4_dispatch: directed stimulus with a delivery scoreboard; the
// stimulus thread queues the expected channel/data of each accepted word and
// a forked monitor pops and compares on every observed delivery.
module tb_demux4_dispatch;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       mode;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  demux4_dispatch #(
    .DW      (8),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [1:0] dst, input logic m,
                               input logic [3:0] rdy);
    in_valid  = v;
    in_data   = d;
    in_dest   = dst;
    mode      = m;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input logic [1:0] ch, input logic [7:0] d);
    exp_q.push_back({ch, d});
  endtask

  // Pops one expected word per observed delivery and compares channel/data
  task automatic monitorDeliveries();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && |(out_valid & out_ready)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL delivery: got valid=%b data=%h, expected no delivery",
                   out_valid, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_valid !== (4'b0001 << e.ch) || out_data !== e.data) begin
            bad++;
            $display("[TB] FAIL delivery: got valid=%b data=%h, expected valid=%b data=%h",
                     out_valid, out_data, 4'b0001 << e.ch, e.data);
          end
        end
      end
    end
  endtask

  // Main directed sequence
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    fork
      monitorDeliveries();
    join_none

    // Reset values
    #12;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_sel",       32'(sel),       32'd0);
    checkOutput("rst_timeout",   32'(timeout),   32'd0);
    tick();
    rst_n = 1'b1;

    // Addressed routing to channel 2
    applyStimulus(1'b1, 8'hA5, 2'd2, 1'b0, 4'b1111);
    expectWord(2'd2, 8'hA5);
    @(negedge clk);
    checkOutput("addr_in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    @(negedge clk);
    checkOutput("addr_out_valid", 32'(out_valid), 32'h4);
    checkOutput("addr_out_data",  32'(out_data),  32'hA5);
    checkOutput("addr_busy",      32'(busy),      32'd1);
    tick();
    @(negedge clk);
    checkOutput("addr_busy_drop", 32'(busy), 32'd0);
    tick();

    // Round-robin streaming, six back-to-back words
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 2'd3, 1'b1, 4'b1111);
      expectWord(2'(i % 4), 8'(8'h10 + i));
      @(negedge clk);
      checkOutput("rr_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        checkOutput("rr_out_valid", 32'(out_valid), 32'(4'b0001 << ((i - 1) % 4)));
      end
      tick();
    end
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    @(negedge clk);
    checkOutput("rr_last_valid", 32'(out_valid), 32'h2);
    tick();

    // Backpressure on channel 1 for five cycles
    applyStimulus(1'b1, 8'h3C, 2'd1, 1'b0, 4'b1101);
    expectWord(2'd1, 8'h3C);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b1101);
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'h2);
      checkOutput("bp_out_data",  32'(out_data),  32'h3C);
      checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 4'b1111;
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    tick();

    // Round-robin timeout: word on channel 3 retargets to channel 0
    applyStimulus(1'b1, 8'h20, 2'd0, 1'b1, 4'b1111);
    expectWord(2'd2, 8'h20);
    tick();
    applyStimulus(1'b1, 8'h21, 2'd0, 1'b1, 4'b1111);
    expectWord(2'd0, 8'h21);
    @(negedge clk);
    checkOutput("rrto_prev_valid", 32'(out_valid), 32'h4);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b0111);
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      checkOutput("rrto_valid",   32'(out_valid), 32'h8);
      checkOutput("rrto_timeout", 32'(timeout),   32'(s == 4));
      tick();
    end
    @(negedge clk);
    checkOutput("rrto_retarget", 32'(out_valid), 32'h1);
    checkOutput("rrto_pulse_end", 32'(timeout), 32'd0);
    tick();

    // Addressed timeout: channel 0 blocked for ten cycles
    applyStimulus(1'b1, 8'h42, 2'd0, 1'b0, 4'b1110);
    expectWord(2'd0, 8'h42);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b1110);
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      checkOutput("ato_valid",   32'(out_valid), 32'h1);
      checkOutput("ato_timeout", 32'(timeout),   32'((s == 4) || (s == 8)));
      tick();
    end
    out_ready = 4'b1111;
    @(negedge clk);
    tick();

    // Delivery on the fourth stall cycle suppresses the pulse
    applyStimulus(1'b1, 8'h43, 2'd3, 1'b0, 4'b0111);
    expectWord(2'd3, 8'h43);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b0111);
    for (int s = 1; s <= 4; s++) begin
      if (s == 4) begin
        out_ready = 4'b1111;
      end
      @(negedge clk);
      checkOutput("prio_timeout", 32'(timeout), 32'd0);
      tick();
    end
    @(negedge clk);
    checkOutput("prio_busy", 32'(busy), 32'd0);
    tick();

    // Reset while holding a round-robin word on channel 1
    applyStimulus(1'b1, 8'h50, 2'd0, 1'b1, 4'b1111);
    expectWord(2'd0, 8'h50);
    tick();
    applyStimulus(1'b1, 8'h77, 2'd0, 1'b1, 4'b1111);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    checkOutput("hold_sel",  32'(sel),  32'd1);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_busy",      32'(busy),      32'd0);
    checkOutput("arst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("arst_sel",       32'(sel),       32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h88, 2'd3, 1'b1, 4'b1111);
    expectWord(2'd0, 8'h88);
    tick();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(out_valid), 32'h1);
    tick();
    tick();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
